// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Instruction-memory fetch bus between fetch_unit and instruction memory.
//   One outstanding request at a time; the request and address stay stable
//   until the memory acknowledges.
//
//   Signals:
//     imem_req    fetch request (fetch unit -> memory)
//     imem_addr   32-bit fetch address (fetch unit -> memory)
//     imem_ack    read data valid for the current request (memory -> fetch unit)
//     imem_rdata  32-bit instruction word (memory -> fetch unit)
//
//   Modports:
//     master  fetch unit side
//     slave   instruction memory side
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Owns the program counter, fetches one instruction
//   at a time over the imem req/ack bus, presents it to decode/control until it
//   is retired, then selects the next PC from the control unit's decision.
//   Fetch and retire never overlap (one instruction per 2 cycles at best).
//
//   Parameters:
//     RESET_PC     PC loaded on reset
//
//   Ports:
//     clk          clock, all state changes on the rising edge
//     rst_n        synchronous active-low reset
//     imem         fetch bus (master modport of fetch_unit_if)
//     instr        registered instruction word (NOP after reset)
//     instr_valid  instr/pc describe an instruction awaiting retirement
//     instr_ready  core retires the presented instruction this cycle
//     pc           address of the current instruction
//     pc_plus4     pc + 4, wraps modulo 2^32
//     pc_src       1 = next PC is pc_target, 0 = pc_plus4 (sampled on retire)
//     pc_target    branch/jump target from the datapath
//     misalign     misaligned-target trap flag
//
//   Build option:
//     FETCH_MISALIGN_TRAP_EN  when defined, a taken target with nonzero low
//                             bits halts the unit and raises misalign until
//                             reset. When undefined, the low two target bits
//                             are cleared and misalign is tied low.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_unit_if.master       imem,
    output logic [31:0]        instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               pc_src,
    input  logic [31:0]        pc_target,
    output logic               misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_c, valid_c;
    logic        accept, retire, trap;

    // An ack only counts while a request is outstanding; ready only in HOLD.
    assign accept   = (state_q == FETCH) && imem.imem_ack;
    assign retire   = (state_q == HOLD) && instr_ready;
    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign trap = retire && pc_src && (pc_target[1:0] != 2'b00);
`else
    logic unused_target_lsbs;

    // Low target bits are discarded in this build; nothing can trap.
    assign unused_target_lsbs = ^pc_target[1:0];
    assign trap               = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = FETCH;
            FETCH:   if (accept) state_d = HOLD;
            HOLD:    if (retire) state_d = trap ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        req_c   = 1'b0;
        valid_c = 1'b0;
        case (state_q)
            FETCH:   req_c   = 1'b1;
            HOLD:    valid_c = 1'b1;
            default: ;
        endcase
    end

    // ---------------- PC / instruction datapath ----------------
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        if (accept) begin
            instr_d = imem.imem_rdata;
        end
        // On a trap the PC stays on the offending instruction.
        if (retire && !trap) begin
            pc_d = pc_src ? {pc_target[31:2], 2'b00} : pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky until reset: HALT has no exit other than reset.
    assign misalign_d = misalign_q | trap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = valid_c;
    assign instr          = instr_q;
    assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A behavioural model tracks the
//   expected PC and the instruction word the memory image returns; each task
//   drives one scenario and compares DUT outputs every cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        misalign;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    // Memory image: a fixed scrambling of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A00_0033;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from the start of its FETCH cycle through retire.
    task automatic run_instr(input int ack_dly, input int rdy_dly,
                             input logic src, input logic [31:0] tgt);
        logic [31:0] exp_p4;
        logic        do_trap;
        // fetch phase: request held until ack; ready/pc_src are ignored here
        for (int i = 0; i <= ack_dly; i++) begin
            exp_p4 = exp_pc + 32'd4;
            checks++;
            if ({bus.imem_req, instr_valid, bus.imem_addr, pc, pc_plus4, instr} !==
                {1'b1, 1'b0, exp_pc, exp_pc, exp_p4, exp_instr}) begin
                errors++;
                $display("FAIL fetch_phase req=%b valid=%b addr=%h pc=%h p4=%h instr=%h expected req=1 valid=0 addr=pc=%h p4=%h instr=%h",
                         bus.imem_req, instr_valid, bus.imem_addr, pc, pc_plus4, instr,
                         exp_pc, exp_p4, exp_instr);
            end
            instr_ready = 1'($urandom);
            pc_src      = 1'($urandom);
            pc_target   = $urandom;
            if (i == ack_dly) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(exp_pc);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
            end
            tick();
        end
        exp_instr = mem_word(exp_pc);
        // hold phase: instruction presented until ready; stray acks ignored
        for (int i = 0; i <= rdy_dly; i++) begin
            exp_p4 = exp_pc + 32'd4;
            checks++;
            if ({bus.imem_req, instr_valid, pc, pc_plus4, instr, misalign} !==
                {1'b0, 1'b1, exp_pc, exp_p4, exp_instr, 1'b0}) begin
                errors++;
                $display("FAIL hold_phase req=%b valid=%b pc=%h p4=%h instr=%h mis=%b expected req=0 valid=1 pc=%h p4=%h instr=%h mis=0",
                         bus.imem_req, instr_valid, pc, pc_plus4, instr, misalign,
                         exp_pc, exp_p4, exp_instr);
            end
            bus.imem_ack   = 1'($urandom);
            bus.imem_rdata = $urandom;
            if (i == rdy_dly) begin
                instr_ready = 1'b1;
                pc_src      = src;
                pc_target   = tgt;
            end else begin
                instr_ready = 1'b0;
                pc_src      = 1'($urandom);
                pc_target   = $urandom;
            end
            tick();
        end
        instr_ready  = 1'b0;
        bus.imem_ack = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        do_trap = src && (tgt[1:0] != 2'b00);
`else
        do_trap = 1'b0;
`endif
        checks++;
        if (do_trap) begin
            if ({bus.imem_req, instr_valid, misalign, pc} !== {1'b0, 1'b0, 1'b1, exp_pc}) begin
                errors++;
                $display("FAIL trap_entry req=%b valid=%b mis=%b pc=%h expected req=0 valid=0 mis=1 pc=%h",
                         bus.imem_req, instr_valid, misalign, pc, exp_pc);
            end
        end else begin
            exp_pc = src ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
            if ({bus.imem_req, instr_valid, bus.imem_addr, misalign} !== {1'b1, 1'b0, exp_pc, 1'b0}) begin
                errors++;
                $display("FAIL next_fetch req=%b valid=%b addr=%h mis=%b expected req=1 valid=0 addr=%h mis=0",
                         bus.imem_req, instr_valid, bus.imem_addr, misalign, exp_pc);
            end
        end
    endtask

    // Applies reset (optionally with an ack in the reset cycle), releases it,
    // checks the BOOT cycle and leaves the DUT at the start of FETCH.
    task automatic do_reset(input int cycles, input logic ack_in_reset);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.imem_ack   = ack_in_reset;
            bus.imem_rdata = $urandom;
            instr_ready    = 1'($urandom);
            tick();
        end
        rst_n        = 1'b1;
        bus.imem_ack = 1'b0;
        instr_ready  = 1'b0;
        checks++;
        if ({bus.imem_req, instr_valid, pc, instr, misalign} !== {1'b0, 1'b0, RST_PC, NOP, 1'b0}) begin
            errors++;
            $display("FAIL reset_state req=%b valid=%b pc=%h instr=%h mis=%b expected req=0 valid=0 pc=%h instr=%h mis=0",
                     bus.imem_req, instr_valid, pc, instr, misalign, RST_PC, NOP);
        end
        exp_pc    = RST_PC;
        exp_instr = NOP;
        tick();
    endtask

    task automatic test_reset();
        do_reset(2, 1'b1);
        run_instr(0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_stream();
        for (int n = 0; n < 4; n++) run_instr(0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_stall();
        run_instr(3, 5, 1'b0, 32'h0);
    endtask

    task automatic test_branch();
        run_instr(0, 0, 1'b1, 32'h0000_0200);
        run_instr(1, 0, 1'b1, 32'hFFFF_FFFC);
        run_instr(0, 1, 1'b0, 32'h0);
        run_instr(0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), $urandom & 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_reset_mid();
        // reset during FETCH with an ack landing in the reset cycle
        do_reset(1, 1'b1);
        run_instr(0, 0, 1'b0, 32'h0);
        // reset during HOLD after a real fetch
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_hold_req got=%b expected=1", bus.imem_req);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(exp_pc);
        tick();
        bus.imem_ack = 1'b0;
        do_reset(1, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0);
    endtask

    task automatic test_misalign();
        run_instr(0, 0, 1'b1, 32'h0000_0202);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack = 1'($urandom);
            instr_ready  = 1'($urandom);
            pc_src       = 1'($urandom);
            tick();
            checks++;
            if ({bus.imem_req, instr_valid, misalign, pc} !== {1'b0, 1'b0, 1'b1, exp_pc}) begin
                errors++;
                $display("FAIL halt_hold req=%b valid=%b mis=%b pc=%h expected req=0 valid=0 mis=1 pc=%h",
                         bus.imem_req, instr_valid, misalign, pc, exp_pc);
            end
        end
        bus.imem_ack = 1'b0;
        do_reset(1, 1'b0);
`endif
        run_instr(0, 0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        instr_ready    = 1'b0;
        pc_src         = 1'b0;
        pc_target      = 32'h0;
        exp_pc         = RST_PC;
        exp_instr      = NOP;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_random();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
